// File: rtl/npc_lsu.sv
// npc_lsu -- multi-cycle load/store unit between ALU/decode and write-back.
//
// Accepts one memory op per in_valid/in_ready handshake and issues a
// word-aligned request with a byte mask on a valid/ready memory port. It
// waits for the one-cycle response pulse, then presents an aligned and
// extended load value with an exception code until write-back takes it.
//
// Optional feature macro: NPC_LSU_PERF_EN (performance counters). When the
// macro is undefined the perf_* outputs are tied to zero.
//
// Ports
//   clk, reset        clock; synchronous active-low reset
//   in_*              op from decode: valid/ready, store flag, funct3,
//                     effective address, store data, rd
//   mem_req_*         request: valid/ready, word address, write enable,
//                     lane-replicated write data, byte write mask
//   mem_resp_*        response pulse and read word
//   out_*             result to write-back: valid/ready, data, rd,
//                     register write enable, exception code
//                     (00 ok, 01 misaligned, 10 bus timeout, 11 illegal funct3)
//   perf_*            completed loads/stores, cycles spent in REQ+WAIT
module npc_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_store,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic [4:0]  in_rd,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    output logic        mem_req_wen,
    output logic [31:0] mem_req_wdata,
    output logic [3:0]  mem_req_wmask,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_rdata,
    output logic [4:0]  out_rd,
    output logic        out_reg_wen,
    output logic [1:0]  out_exc,
    output logic [31:0] perf_loads,
    output logic [31:0] perf_stores,
    output logic [31:0] perf_stalls
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t      state, state_nxt;
    logic        op_store;
    logic [2:0]  op_funct3;
    logic [1:0]  op_lo;
    logic [31:0] tmo_cnt;
    logic        accept;
    logic        acc_legal;
    logic        acc_misaligned;
    logic        tmo_hit;

    function automatic logic [3:0] store_mask(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            2'b00:   return 4'b0001 << lo;
            2'b01:   return 4'b0011 << lo;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            2'b00:   return {4{wdata[7:0]}};
            2'b01:   return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] lo,
                                                input logic [31:0] word);
        logic [31:0] sh;
        sh = word >> {lo, 3'b000};
        case (f3)
            3'b000:  return {{24{sh[7]}}, sh[7:0]};
            3'b001:  return {{16{sh[15]}}, sh[15:0]};
            3'b100:  return {24'd0, sh[7:0]};
            3'b101:  return {16'd0, sh[15:0]};
            default: return word;
        endcase
    endfunction

    assign in_ready      = (state == IDLE) && reset;
    assign mem_req_valid = (state == REQ);
    assign out_valid     = (state == DONE);
    assign accept        = in_valid && in_ready;

    always_comb begin
        acc_legal = 1'b0;
        if (in_store)
            acc_legal = (in_funct3 == 3'b000) || (in_funct3 == 3'b001) || (in_funct3 == 3'b010);
        else
            acc_legal = (in_funct3 == 3'b000) || (in_funct3 == 3'b001) || (in_funct3 == 3'b010) ||
                        (in_funct3 == 3'b100) || (in_funct3 == 3'b101);
    end

    // Halfword needs addr[0] clear, word needs addr[1:0] clear; bytes never fault.
    assign acc_misaligned = ((in_funct3[1:0] == 2'b01) && in_addr[0]) ||
                            ((in_funct3[1:0] == 2'b10) && (in_addr[1:0] != 2'b00));

    // Fires on the WAIT cycle that would bring the silent-cycle count to the limit.
    assign tmo_hit = (TIMEOUT_CYCLES != 0) && ((tmo_cnt + 32'd1) == TIMEOUT_CYCLES);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = (acc_legal && !acc_misaligned) ? REQ : DONE;
            REQ:  if (mem_req_ready) state_nxt = WAIT;
            WAIT: if (mem_resp_valid || tmo_hit) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            op_store      <= 1'b0;
            op_funct3     <= 3'd0;
            op_lo         <= 2'd0;
            tmo_cnt       <= 32'd0;
            mem_req_addr  <= 32'd0;
            mem_req_wen   <= 1'b0;
            mem_req_wdata <= 32'd0;
            mem_req_wmask <= 4'd0;
            out_rdata     <= 32'd0;
            out_rd        <= 5'd0;
            out_reg_wen   <= 1'b0;
            out_exc       <= 2'd0;
        end else begin
            case (state)
                // accept: capture op, classify, build the request
                IDLE: if (accept) begin
                    op_store    <= in_store;
                    op_funct3   <= in_funct3;
                    op_lo       <= in_addr[1:0];
                    out_rd      <= in_rd;
                    out_rdata   <= 32'd0;
                    out_reg_wen <= 1'b0;
                    if (!acc_legal)
                        out_exc <= 2'b11;
                    else if (acc_misaligned)
                        out_exc <= 2'b01;
                    else begin
                        out_exc       <= 2'b00;
                        mem_req_addr  <= {in_addr[31:2], 2'b00};
                        mem_req_wen   <= in_store;
                        mem_req_wdata <= in_store ? store_data(in_funct3[1:0], in_wdata) : 32'd0;
                        mem_req_wmask <= in_store ? store_mask(in_funct3[1:0], in_addr[1:0]) : 4'd0;
                    end
                end
                // request handshake: start the response timeout window
                REQ: if (mem_req_ready) tmo_cnt <= 32'd0;
                // response or timeout: form the write-back result
                WAIT: begin
                    if (mem_resp_valid) begin
                        out_rdata   <= op_store ? 32'd0 : load_extend(op_funct3, op_lo, mem_resp_rdata);
                        out_reg_wen <= !op_store;
                    end else begin
                        tmo_cnt <= tmo_cnt + 32'd1;
                        if (tmo_hit) begin
                            out_exc   <= 2'b10;
                            out_rdata <= 32'd0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef NPC_LSU_PERF_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_loads  <= 32'd0;
            perf_stores <= 32'd0;
            perf_stalls <= 32'd0;
        end else begin
            if (out_valid && out_ready && (out_exc == 2'b00)) begin
                if (op_store) perf_stores <= perf_stores + 32'd1;
                else          perf_loads  <= perf_loads + 32'd1;
            end
            if ((state == REQ) || (state == WAIT))
                perf_stalls <= perf_stalls + 32'd1;
        end
    end
`else
    assign perf_loads  = 32'd0;
    assign perf_stores = 32'd0;
    assign perf_stalls = 32'd0;
`endif

endmodule

// File: tb/tb_npc_lsu.sv
// Directed bench for npc_lsu built with TIMEOUT_CYCLES = 4.
module tb_npc_lsu;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_store = 1'b0;
    logic [2:0]  in_funct3 = 3'd0;
    logic [31:0] in_addr = 32'd0;
    logic [31:0] in_wdata = 32'd0;
    logic [4:0]  in_rd = 5'd0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_req_addr;
    logic        mem_req_wen;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wmask;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_rdata = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_rdata;
    logic [4:0]  out_rd;
    logic        out_reg_wen;
    logic [1:0]  out_exc;
    logic [31:0] perf_loads;
    logic [31:0] perf_stores;
    logic [31:0] perf_stalls;

    int passed = 0;
    int total  = 0;

    npc_lsu #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_store(in_store),
        .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
        .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata),
        .out_rd(out_rd), .out_reg_wen(out_reg_wen), .out_exc(out_exc),
        .perf_loads(perf_loads), .perf_stores(perf_stores), .perf_stalls(perf_stalls)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Present an op for exactly one accepting edge.
    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] rd);
        in_store = st; in_funct3 = f3; in_addr = a; in_wdata = wd; in_rd = rd;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    // Full op with mem_req_ready high and the response in the first WAIT cycle; ends in DONE.
    task automatic run_op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [4:0] rd, input logic [31:0] word);
        mem_req_ready = 1'b1;
        issue(st, f3, a, wd, rd);
        step();
        mem_resp_valid = 1'b1; mem_resp_rdata = word;
        step();
        mem_resp_valid = 1'b0;
    endtask

    task automatic retire();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        // reset state
        step(); step();
        chk("rst_in_ready_low", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
        chk("rst_out_rdata", out_rdata, 32'd0);
        chk("rst_req_addr", mem_req_addr, 32'd0);
        chk("rst_perf_stalls", perf_stalls, 32'd0);
        reset = 1'b1;
        #1;
        chk("idle_in_ready", 32'(in_ready), 32'd1);

        // lb at byte 3, sign-extended
        mem_req_ready = 1'b1;
        issue(1'b0, 3'b000, 32'h8000_0003, 32'd0, 5'd7);
        chk("lb_req_valid", 32'(mem_req_valid), 32'd1);
        chk("lb_req_addr", mem_req_addr, 32'h8000_0000);
        chk("lb_req_wen", 32'(mem_req_wen), 32'd0);
        chk("lb_req_wmask", 32'(mem_req_wmask), 32'd0);
        chk("lb_in_ready_busy", 32'(in_ready), 32'd0);
        step();
        chk("lb_wait_no_valid", 32'(out_valid), 32'd0);
        mem_resp_valid = 1'b1; mem_resp_rdata = 32'h80FF_7F01;
        step();
        mem_resp_valid = 1'b0;
        chk("lb_out_valid", 32'(out_valid), 32'd1);
        chk("lb_rdata", out_rdata, 32'hFFFF_FF80);
        chk("lb_reg_wen", 32'(out_reg_wen), 32'd1);
        chk("lb_exc", 32'(out_exc), 32'd0);
        chk("lb_rd", 32'(out_rd), 32'd7);
        retire();
        chk("lb_retired", 32'(out_valid), 32'd0);
        chk("lb_back_idle", 32'(in_ready), 32'd1);

        run_op(1'b0, 3'b100, 32'h8000_0003, 32'd0, 5'd8, 32'h80FF_7F01);
        chk("lbu_rdata", out_rdata, 32'h0000_0080);
        retire();
        run_op(1'b0, 3'b001, 32'h8000_0002, 32'd0, 5'd9, 32'h80FF_7F01);
        chk("lh_rdata", out_rdata, 32'hFFFF_80FF);
        retire();
        run_op(1'b0, 3'b101, 32'h8000_0002, 32'd0, 5'd9, 32'h80FF_7F01);
        chk("lhu_rdata", out_rdata, 32'h0000_80FF);
        retire();

        // sh with the request held off for 5 cycles
        mem_req_ready = 1'b0;
        issue(1'b1, 3'b001, 32'h8000_0002, 32'h1234_BEEF, 5'd3);
        for (int i = 0; i < 5; i++) begin
            chk("sh_hold_valid", 32'(mem_req_valid), 32'd1);
            chk("sh_hold_addr", mem_req_addr, 32'h8000_0000);
            chk("sh_hold_wdata", mem_req_wdata, 32'hBEEF_BEEF);
            chk("sh_hold_wmask", 32'(mem_req_wmask), 32'hC);
            chk("sh_hold_wen", 32'(mem_req_wen), 32'd1);
            step();
        end
        mem_req_ready = 1'b1;
        step();
        chk("sh_req_dropped", 32'(mem_req_valid), 32'd0);
        mem_resp_valid = 1'b1; mem_resp_rdata = 32'hDEAD_BEEF;
        step();
        mem_resp_valid = 1'b0;
        // write-back stalled for 3 cycles
        for (int i = 0; i < 3; i++) begin
            chk("sh_done_valid", 32'(out_valid), 32'd1);
            chk("sh_done_reg_wen", 32'(out_reg_wen), 32'd0);
            chk("sh_done_exc", 32'(out_exc), 32'd0);
            chk("sh_done_rdata", out_rdata, 32'd0);
            chk("sh_done_in_ready", 32'(in_ready), 32'd0);
            step();
        end
        retire();

        // sb / sw lane handling
        mem_req_ready = 1'b0;
        issue(1'b1, 3'b000, 32'h8000_0001, 32'h0000_00AB, 5'd0);
        chk("sb_wmask", 32'(mem_req_wmask), 32'h2);
        chk("sb_wdata", mem_req_wdata, 32'hABAB_ABAB);
        mem_req_ready = 1'b1;
        step();
        mem_resp_valid = 1'b1;
        step();
        mem_resp_valid = 1'b0;
        retire();
        mem_req_ready = 1'b0;
        issue(1'b1, 3'b010, 32'h8000_0004, 32'hCAFE_F00D, 5'd0);
        chk("sw_wmask", 32'(mem_req_wmask), 32'hF);
        chk("sw_wdata", mem_req_wdata, 32'hCAFE_F00D);
        chk("sw_addr", mem_req_addr, 32'h8000_0004);
        mem_req_ready = 1'b1;
        step();
        mem_resp_valid = 1'b1;
        step();
        mem_resp_valid = 1'b0;
        retire();

        // exceptions skip the memory port
        issue(1'b0, 3'b010, 32'h8000_0006, 32'd0, 5'd4);
        chk("mis_req_valid", 32'(mem_req_valid), 32'd0);
        chk("mis_out_valid", 32'(out_valid), 32'd1);
        chk("mis_exc", 32'(out_exc), 32'd1);
        chk("mis_reg_wen", 32'(out_reg_wen), 32'd0);
        retire();
        issue(1'b0, 3'b011, 32'h8000_0000, 32'd0, 5'd4);
        chk("ill_req_valid", 32'(mem_req_valid), 32'd0);
        chk("ill_exc", 32'(out_exc), 32'd3);
        retire();
        issue(1'b1, 3'b100, 32'h8000_0000, 32'd0, 5'd4);
        chk("ill_st_exc", 32'(out_exc), 32'd3);
        chk("ill_st_req_valid", 32'(mem_req_valid), 32'd0);
        retire();

        // bus timeout after 4 silent WAIT cycles
        issue(1'b0, 3'b010, 32'h8000_0010, 32'd0, 5'd5);
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("tmo_pending", 32'(out_valid), 32'd0);
        end
        step();
        chk("tmo_out_valid", 32'(out_valid), 32'd1);
        chk("tmo_exc", 32'(out_exc), 32'd2);
        chk("tmo_rdata", out_rdata, 32'd0);
        chk("tmo_reg_wen", 32'(out_reg_wen), 32'd0);
        retire();

        // reset in WAIT, then a late response
        issue(1'b0, 3'b010, 32'h8000_0020, 32'd0, 5'd6);
        step();
        step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        mem_resp_valid = 1'b1; mem_resp_rdata = 32'h1111_1111;
        step();
        mem_resp_valid = 1'b0;
        step();
        chk("late_out_valid", 32'(out_valid), 32'd0);
        chk("late_in_ready", 32'(in_ready), 32'd1);
        chk("late_req_valid", 32'(mem_req_valid), 32'd0);
        chk("late_rdata", out_rdata, 32'd0);
        chk("late_perf_stalls", perf_stalls, 32'd0);

        // 3 loads + 2 stores since reset
        run_op(1'b0, 3'b010, 32'h8000_0000, 32'd0, 5'd1, 32'h1234_5678);
        chk("lw_rdata", out_rdata, 32'h1234_5678);
        retire();
        run_op(1'b0, 3'b000, 32'h8000_0003, 32'd0, 5'd2, 32'h80FF_7F01);
        retire();
        run_op(1'b0, 3'b100, 32'h8000_0001, 32'd0, 5'd3, 32'h80FF_7F01);
        chk("lbu_b1_rdata", out_rdata, 32'h0000_007F);
        retire();
        run_op(1'b1, 3'b010, 32'h8000_0008, 32'h5555_AAAA, 5'd0, 32'd0);
        retire();
        run_op(1'b1, 3'b000, 32'h8000_000B, 32'h0000_0033, 5'd0, 32'd0);
        retire();
`ifdef NPC_LSU_PERF_EN
        chk("perf_loads", perf_loads, 32'd3);
        chk("perf_stores", perf_stores, 32'd2);
        chk("perf_stalls", perf_stalls, 32'd10);
`else
        chk("perf_loads_off", perf_loads, 32'd0);
        chk("perf_stores_off", perf_stores, 32'd0);
        chk("perf_stalls_off", perf_stalls, 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
